// File: rtl/axi_line_pkg.sv
// Shared constants for the dcache line-refill / write-back AXI responder.
// FSM state codes stay plain localparams so older tooling can read them.
package axi_line_pkg;

  localparam int LINE_BEATS = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_WFILL  = 4'd1;
  localparam logic [3:0] ST_AW     = 4'd2;
  localparam logic [3:0] ST_W      = 4'd3;
  localparam logic [3:0] ST_B      = 4'd4;
  localparam logic [3:0] ST_AR     = 4'd5;
  localparam logic [3:0] ST_R      = 4'd6;
  localparam logic [3:0] ST_STREAM = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;

endpackage

// File: rtl/line_buf.sv
// One-line staging buffer shared by the refill and write-back paths:
// one synchronous write port and one combinational read port.
module line_buf #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int IDX_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [BEATS];

  // NOTE: storage has no reset; every beat is written before it is read.
  always_ff @(posedge clk) begin
    if (wen) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/axi_line_ctl.sv
// Converts one 64-byte cache line request into a single 8-beat AXI4 INCR
// burst, buffering write-back data beforehand and streaming refills after.
module axi_line_ctl
  import axi_line_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BEATS  = LINE_BEATS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_req,
  input  logic                line_rw,
  input  logic [ADDR_W-1:0]   line_addr,
  input  logic                wbuf_wen,
  input  logic [DATA_W-1:0]   wbuf_data,
  output logic                ready_o,
  output logic                done_o,
  output logic                err_o,
  output logic                rdata_valid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [2:0]          rbeat_o,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W:0]   FULL_CNT  = (BEAT_W + 1)'(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W:0]   wbuf_cnt_q, wbuf_cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic              out_en_q, out_en_d;

  logic              push_ok;
  logic              wbuf_full;
  logic              buf_wen;
  logic [BEAT_W-1:0] buf_widx;
  logic [DATA_W-1:0] buf_wdata;
  logic [DATA_W-1:0] buf_rdata;

  assign wbuf_full = (wbuf_cnt_q == FULL_CNT);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wbuf_cnt_d = wbuf_cnt_q;
    beat_d     = beat_q;
    err_d      = err_q;
    out_en_d   = 1'b1;

    push_ok = wbuf_wen && !wbuf_full && (state_q == ST_IDLE || state_q == ST_WFILL);
    if (push_ok) wbuf_cnt_d = wbuf_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (line_req && out_en_q) begin
          addr_d = line_addr & LINE_MASK;
          if (!line_rw)       state_d = ST_AR;
          else if (wbuf_full) state_d = ST_AW;
          else                state_d = ST_WFILL;
        end
      end
      ST_WFILL: if (wbuf_full) state_d = ST_AW;
      ST_AW:    if (awready)   state_d = ST_W;
      ST_W: begin
        if (wready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_B;
        end
      end
      ST_B: begin
        if (bvalid) begin
          if (bresp != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_AR: if (arready) state_d = ST_R;
      ST_R: begin
        if (rvalid) begin
          beat_d = beat_q + 1'b1;
          // A misplaced rlast is flagged but never ends the burst early.
          if (rresp != AXI_RESP_OKAY || rlast != (beat_q == LAST_BEAT)) err_d = 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!line_req) begin
          state_d    = ST_IDLE;
          wbuf_cnt_d = '0;
          beat_d     = '0;
          err_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wbuf_cnt_q <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wbuf_cnt_q <= wbuf_cnt_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      out_en_q   <= out_en_d;
    end
  end

  assign buf_wen   = push_ok || (state_q == ST_R && rvalid);
  assign buf_widx  = (state_q == ST_R) ? beat_q : wbuf_cnt_q[BEAT_W-1:0];
  assign buf_wdata = (state_q == ST_R) ? rdata : wbuf_data;

  line_buf #(.DATA_W(DATA_W), .BEATS(BEATS), .IDX_W(BEAT_W)) u_line_buf (
    .clk   (clk),
    .wen   (buf_wen),
    .widx  (buf_widx),
    .wdata (buf_wdata),
    .ridx  (beat_q),
    .rdata (buf_rdata)
  );

  // ready_o stays low through reset and rises the cycle after rst drops.
  assign ready_o       = (state_q == ST_IDLE) && out_en_q;
  assign done_o        = (state_q == ST_DONE);
  assign err_o         = done_o && err_q;
  assign rdata_valid_o = (state_q == ST_STREAM);
  assign rdata_o       = rdata_valid_o ? buf_rdata : '0;
  assign rbeat_o       = rdata_valid_o ? 3'(beat_q) : 3'd0;

  assign arvalid = (state_q == ST_AR);
  assign araddr  = arvalid ? addr_q : '0;
  assign arlen   = arvalid ? 8'(BEATS - 1) : 8'd0;
  assign arsize  = arvalid ? AXI_SIZE_8B : 3'd0;
  assign arburst = arvalid ? AXI_BURST_INCR : 2'd0;
  assign rready  = (state_q == ST_R);

  assign awvalid = (state_q == ST_AW);
  assign awaddr  = awvalid ? addr_q : '0;
  assign awlen   = awvalid ? 8'(BEATS - 1) : 8'd0;
  assign awsize  = awvalid ? AXI_SIZE_8B : 3'd0;
  assign awburst = awvalid ? AXI_BURST_INCR : 2'd0;

  assign wvalid = (state_q == ST_W);
  assign wdata  = wvalid ? buf_rdata : '0;
  assign wstrb  = wvalid ? '1 : '0;
  assign wlast  = wvalid && (beat_q == LAST_BEAT);
  assign bready = (state_q == ST_B);

endmodule
